// File: rtl/nf10_axis_tx_stim_gen_if.sv
// AXI4-Stream bundle for the TX stimulus generator: master drives the beat, slave drives tready.
interface nf10_axis_tx_stim_gen_if #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned UserWidth = 128
);
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tkeep;
    logic [UserWidth-1:0]   tuser;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tkeep, output tuser, output tvalid, output tlast,
                    input tready);
    modport slave (input tdata, input tkeep, input tuser, input tvalid, input tlast,
                   output tready);
endinterface

// File: rtl/nf10_axis_tx_stim_gen.sv
// TX-direction AXI4-Stream packet source: numbered, pattern-filled packets with NetFPGA tuser
// metadata, so port-side capture can be checked without a stimulus file.
module nf10_axis_tx_stim_gen #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT           = 8'h02,
    parameter int unsigned C_MIN_LEN            = 60
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic                    start,
    input  logic                    stop,
    input  logic [15:0]             cfg_pkt_len,
    input  logic [15:0]             cfg_pkt_count,
    input  logic [7:0]              cfg_dst_port,
    input  logic [7:0]              cfg_ipg,
    nf10_axis_tx_stim_gen_if.master m_axis,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             pkt_sent
);
    localparam int unsigned Bytes = C_M_AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [15:0]                     len_q, len_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic [7:0]                      dst_q, dst_d;
    logic [7:0]                      ipg_q, ipg_d;
    logic [7:0]                      gap_q, gap_d;
    logic [7:0]                      seq_q, seq_d;
    logic [15:0]                     idx_q, idx_d;
    logic                            stop_req_q, stop_req_d;
    logic [31:0]                     pkt_sent_q, pkt_sent_d;
    logic                            busy_q, done_q;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_q;
    logic [Bytes-1:0]                tkeep_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q;

    logic                            load;
    logic                            hs;
    logic                            stop_eff;
    logic [15:0]                     len_cfg;

    logic [C_M_AXIS_DATA_WIDTH-1:0]  bld_data;
    logic [Bytes-1:0]                bld_keep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] bld_user;
    logic                            bld_last;
    logic [31:0]                     bld_off;
    logic [31:0]                     bld_rem;

    assign hs       = tvalid_q & m_axis.tready;
    assign stop_eff = stop | stop_req_q;
    assign len_cfg  = (cfg_pkt_len < 16'(C_MIN_LEN)) ? 16'(C_MIN_LEN) : cfg_pkt_len;

    // Control path; `load` requests the beat described by seq_d/idx_d/len_d/dst_d.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        dst_d      = dst_q;
        ipg_d      = ipg_q;
        gap_d      = gap_q;
        seq_d      = seq_q;
        idx_d      = idx_q;
        stop_req_d = stop_req_q;
        pkt_sent_d = pkt_sent_q;
        tvalid_d   = tvalid_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    stop_req_d = stop;
                    if (cfg_pkt_count == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StSend;
                        len_d    = len_cfg;
                        cnt_d    = cfg_pkt_count;
                        dst_d    = cfg_dst_port;
                        ipg_d    = cfg_ipg;
                        seq_d    = 8'd0;
                        idx_d    = 16'd0;
                        load     = 1'b1;
                        tvalid_d = 1'b1;
                    end
                end
            end
            StSend: begin
                stop_req_d = stop_req_q | stop;
                if (hs) begin
                    if (!tlast_q) begin
                        idx_d = idx_q + 16'd1;
                        load  = 1'b1;
                    end else begin
                        pkt_sent_d = pkt_sent_q + 32'd1;
                        cnt_d      = cnt_q - 16'd1;
                        if (cnt_q == 16'd1 || stop_eff) begin
                            state_d  = StDone;
                            tvalid_d = 1'b0;
                        end else begin
                            seq_d = seq_q + 8'd1;
                            idx_d = 16'd0;
                            if (ipg_q == 8'd0) begin
                                load = 1'b1;
                            end else begin
                                state_d  = StGap;
                                gap_d    = ipg_q;
                                tvalid_d = 1'b0;
                            end
                        end
                    end
                end
            end
            StGap: begin
                if (stop_eff) begin
                    state_d = StDone;
                end else if (gap_q == 8'd1) begin
                    // Last idle cycle: stage the next packet's first beat.
                    state_d  = StSend;
                    load     = 1'b1;
                    tvalid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StDone: begin
                state_d    = StIdle;
                stop_req_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat builder: byte k of packet n carries (n + k) mod 256, zero past the packet end.
    always_comb begin
        bld_off  = 32'(idx_d) * 32'(Bytes);
        bld_rem  = 32'(len_d) - bld_off;
        bld_last = (bld_rem <= 32'(Bytes));
        bld_data = '0;
        bld_keep = '0;
        for (int j = 0; j < int'(Bytes); j++) begin
            if (32'(j) < bld_rem) begin
                bld_keep[j]        = 1'b1;
                bld_data[8*j +: 8] = seq_d + 8'(bld_off + 32'(j));
            end
        end
        bld_user = '0;
        if (idx_d == 16'd0) begin
            bld_user[15:0]  = len_d;
            bld_user[23:16] = C_SRC_PORT;
            bld_user[31:24] = dst_d;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            dst_q      <= '0;
            ipg_q      <= '0;
            gap_q      <= '0;
            seq_q      <= '0;
            idx_q      <= '0;
            stop_req_q <= 1'b0;
            pkt_sent_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tuser_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            dst_q      <= dst_d;
            ipg_q      <= ipg_d;
            gap_q      <= gap_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            stop_req_q <= stop_req_d;
            pkt_sent_q <= pkt_sent_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            tvalid_q   <= tvalid_d;
            if (load) begin
                tdata_q <= bld_data;
                tkeep_q <= bld_keep;
                tuser_q <= bld_user;
                tlast_q <= bld_last;
            end else if (!tvalid_d) begin
                tdata_q <= '0;
                tkeep_q <= '0;
                tuser_q <= '0;
                tlast_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_sent      = pkt_sent_q;
endmodule

// File: tb/tb_nf10_axis_tx_stim_gen.sv
// Directed bench for nf10_axis_tx_stim_gen: runs short packet sequences and checks every beat
// against the payload/tkeep/tuser formula plus hand-computed constants.
module tb_nf10_axis_tx_stim_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] cfg_pkt_len;
    logic [15:0] cfg_pkt_count;
    logic [7:0]  cfg_dst_port;
    logic [7:0]  cfg_ipg;
    logic        busy;
    logic        done;
    logic [31:0] pkt_sent;

    int ntotal = 0;
    int nbad   = 0;
    int cyc    = 0;

    logic [127:0] cap_user;
    logic [255:0] cap_first_data;
    logic [255:0] cap_last_data;
    logic [31:0]  cap_last_keep;

    nf10_axis_tx_stim_gen_if m_axis ();

    nf10_axis_tx_stim_gen dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .start         (start),
        .stop          (stop),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_count (cfg_pkt_count),
        .cfg_dst_port  (cfg_dst_port),
        .cfg_ipg       (cfg_ipg),
        .m_axis        (m_axis),
        .busy          (busy),
        .done          (done),
        .pkt_sent      (pkt_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        ntotal++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_data(input int n, input int b, input int l);
        logic [255:0] d;
        d = '0;
        for (int j = 0; j < 32; j++) begin
            if (b * 32 + j < l) d[8*j +: 8] = 8'((n + b * 32 + j) % 256);
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_keep(input int b, input int l);
        int r;
        r = l - b * 32;
        if (r >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << r) - 32'h1;
    endfunction

    task automatic start_run(input logic [15:0] len, input logic [15:0] cnt,
                             input logic [7:0] dst, input logic [7:0] ipg, output int st);
        @(negedge clk);
        cfg_pkt_len   = len;
        cfg_pkt_count = cnt;
        cfg_dst_port  = dst;
        cfg_ipg       = ipg;
        start         = 1'b1;
        st            = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble config: the run must keep using the latched values.
        cfg_pkt_len   = ~len;
        cfg_pkt_count = 16'd0;
        cfg_dst_port  = 8'h00;
        cfg_ipg       = 8'hFF;
    endtask

    // mode: 0 tready=1, 1 toggling, 2 random. stop_beat: raise stop on that beat's handshake.
    task automatic rx_pkt(input int n, input int len, input logic [7:0] dst, input int mode,
                          input int stop_beat, output int first_cyc, output int last_cyc);
        int l, beats, b, spins;
        bit started, phase;
        logic [255:0] ed;
        logic [127:0] eu;
        l = (len < 60) ? 60 : len;
        beats = (l + 31) / 32;
        b = 0; spins = 0; started = 0; phase = 0; first_cyc = -1; last_cyc = -1;
        while (b < beats) begin
            @(negedge clk);
            spins++;
            if (spins > 1000) begin
                check_val("rx_timeout", 256'(b), 256'(beats));
                m_axis.tready = 1'b1;
                return;
            end
            if (!started) begin
                if (!m_axis.tvalid) continue;
                started = 1; first_cyc = cyc;
            end else begin
                check_val("tvalid_hold", 256'(m_axis.tvalid), 256'(1));
                if (!m_axis.tvalid) return;
            end
            ed = exp_data(n, b, l);
            eu = '0;
            if (b == 0) eu[31:0] = {dst, 8'h02, 16'(l)};
            check_val("tdata", m_axis.tdata, ed);
            check_val("tkeep", 256'(m_axis.tkeep), 256'(exp_keep(b, l)));
            check_val("tuser", 256'(m_axis.tuser), 256'(eu));
            check_val("tlast", 256'(m_axis.tlast), 256'(b == beats - 1));
            if (b == 0) begin
                cap_user       = m_axis.tuser;
                cap_first_data = m_axis.tdata;
            end
            if (b == beats - 1) begin
                cap_last_data = m_axis.tdata;
                cap_last_keep = m_axis.tkeep;
            end
            if (mode == 1) begin
                phase = ~phase;
                m_axis.tready = phase;
            end else if (mode == 2) begin
                m_axis.tready = 1'($urandom_range(0, 1));
            end else begin
                m_axis.tready = 1'b1;
            end
            if (m_axis.tready) begin
                if (b == stop_beat) stop = 1'b1;
                if (b == beats - 1) last_cyc = cyc;
                b++;
            end
        end
        m_axis.tready = 1'b1;
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check_val({tag, "_done_hi"}, 256'(done), 256'(1));
        check_val({tag, "_busy_hi"}, 256'(busy), 256'(1));
        check_val({tag, "_tvalid_lo"}, 256'(m_axis.tvalid), 256'(0));
        @(negedge clk);
        check_val({tag, "_done_lo"}, 256'(done), 256'(0));
        check_val({tag, "_busy_lo"}, 256'(busy), 256'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val({tag, "_tvalid"}, 256'(m_axis.tvalid), 256'(0));
        check_val({tag, "_tlast"}, 256'(m_axis.tlast), 256'(0));
        check_val({tag, "_tdata"}, m_axis.tdata, 256'(0));
        check_val({tag, "_tkeep"}, 256'(m_axis.tkeep), 256'(0));
        check_val({tag, "_tuser"}, 256'(m_axis.tuser), 256'(0));
        check_val({tag, "_busy"}, 256'(busy), 256'(0));
        check_val({tag, "_done"}, 256'(done), 256'(0));
        check_val({tag, "_pkt_sent"}, 256'(pkt_sent), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, f0, l0, f1, l1, f2, l2;
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_pkt_len = '0; cfg_pkt_count = '0; cfg_dst_port = '0; cfg_ipg = '0;
        m_axis.tready = 1'b1;
        do_reset("rst0");

        // T1: 64 bytes, one packet
        start_run(16'd64, 16'd1, 8'h01, 8'd0, st);
        rx_pkt(0, 64, 8'h01, 0, -1, f0, l0);
        check_val("t1_latency", 256'(f0 - st), 256'(1));
        check_val("t1_tuser", 256'(cap_user[31:0]), 256'(32'h0102_0040));
        check_val("t1_byte0", 256'(cap_first_data[7:0]), 256'(8'h00));
        check_val("t1_byte63", 256'(cap_last_data[255:248]), 256'(8'h3F));
        check_val("t1_lastkeep", 256'(cap_last_keep), 256'(32'hFFFF_FFFF));
        check_done("t1");
        check_val("t1_pkt_sent", 256'(pkt_sent), 256'(1));

        // stop while idle must not affect the next run
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;

        // T2: 65 bytes, two packets, 3-cycle gap
        start_run(16'd65, 16'd2, 8'h04, 8'd3, st);
        rx_pkt(0, 65, 8'h04, 0, -1, f0, l0);
        rx_pkt(1, 65, 8'h04, 0, -1, f1, l1);
        check_val("t2_gap", 256'(f1 - l0 - 1), 256'(3));
        check_val("t2_lastkeep", 256'(cap_last_keep), 256'(32'h0000_0001));
        check_val("t2_p1_byte0", 256'(cap_first_data[7:0]), 256'(8'h01));
        check_done("t2");
        check_val("t2_pkt_sent", 256'(pkt_sent), 256'(3));

        // T3: short length is clamped to 60
        start_run(16'd10, 16'd1, 8'h10, 8'd0, st);
        rx_pkt(0, 10, 8'h10, 0, -1, f0, l0);
        check_val("t3_len", 256'(cap_user[15:0]), 256'(16'h003C));
        check_val("t3_tuser", 256'(cap_user[31:0]), 256'(32'h1002_003C));
        check_val("t3_lastkeep", 256'(cap_last_keep), 256'(32'h0FFF_FFFF));
        check_done("t3");

        // T4: backpressure, 100 bytes x4
        do_reset("rst4");
        start_run(16'd100, 16'd4, 8'h40, 8'd1, st);
        rx_pkt(0, 100, 8'h40, 1, -1, f0, l0);
        rx_pkt(1, 100, 8'h40, 1, -1, f1, l1);
        check_val("t4_gap", 256'(f1 - l1 + l1 - l0 - 1 - (f1 - l0 - 1) + 1), 256'(1));
        rx_pkt(2, 100, 8'h40, 2, -1, f2, l2);
        check_val("t4_lastkeep", 256'(cap_last_keep), 256'(32'h0000_000F));
        rx_pkt(3, 100, 8'h40, 2, -1, f0, l0);
        check_val("t4_gap3", 256'(f0 - l2 - 1), 256'(1));
        check_done("t4");
        check_val("t4_pkt_sent", 256'(pkt_sent), 256'(4));

        // T5: zero-count run
        start_run(16'd64, 16'd0, 8'h01, 8'd0, st);
        @(negedge clk);
        check_val("t5_delay", 256'(cyc - st), 256'(1));
        check_val("t5_tvalid", 256'(m_axis.tvalid), 256'(0));
        check_val("t5_busy", 256'(busy), 256'(1));
        check_val("t5_done", 256'(done), 256'(1));
        @(negedge clk);
        check_val("t5_busy_lo", 256'(busy), 256'(0));
        check_val("t5_done_lo", 256'(done), 256'(0));
        check_val("t5_pkt_sent", 256'(pkt_sent), 256'(4));

        // T6: stop during packet 2, back-to-back packets
        do_reset("rst6");
        start_run(16'd64, 16'd8, 8'h01, 8'd0, st);
        rx_pkt(0, 64, 8'h01, 0, -1, f0, l0);
        rx_pkt(1, 64, 8'h01, 0, -1, f1, l1);
        check_val("t6_gap", 256'(f1 - l0 - 1), 256'(0));
        rx_pkt(2, 64, 8'h01, 0, 0, f2, l2);
        check_done("t6");
        check_val("t6_pkt_sent", 256'(pkt_sent), 256'(3));
        stop = 1'b0;

        // Reset in the middle of a new run
        start_run(16'd200, 16'd2, 8'h04, 8'd1, st);
        repeat (3) @(negedge clk);
        check_val("t6_run_valid", 256'(m_axis.tvalid), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_tvalid", 256'(m_axis.tvalid), 256'(0));
        check_val("t6_rst_pkt_sent", 256'(pkt_sent), 256'(0));
        check_val("t6_rst_busy", 256'(busy), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t6_no_resume", 256'(m_axis.tvalid), 256'(0));
        check_val("t6_idle_busy", 256'(busy), 256'(0));

        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end
endmodule
